// File: rtl/ram8_port_ctrl_if.sv
// Host-side request/response bundle for the ram8 port controller.
// The controller sits on the slave modport; the host drives the master modport.
interface ram8_port_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/ram8_port_ctrl.sv
// Single-port controller for an 8-word ram8: host reads/writes in IDLE,
// plus a hardware fill sequence that writes one latched value to all words.
module ram8_port_ctrl #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  ram8_port_ctrl_if.slave   host,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              fill_done,
  output logic              ram_load,
  output logic [2:0]        ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic [DATA_W-1:0] fill_val;
  logic              req_ready_c;
  logic              accept, fill_go, fill_last, load_c;
  logic              rsp_vld_p1;
  logic [DATA_W-1:0] rsp_data_p1;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    req_ready_c = 1'b0;
    accept      = 1'b0;
    fill_go     = 1'b0;
    fill_last   = 1'b0;
    load_c      = 1'b0;
    ram_address = host.req_addr;
    ram_data_in = host.req_wdata;
    case (state)
      IDLE: begin
        // fill_start wins over a simultaneous host request
        req_ready_c = ~fill_start;
        accept      = host.req_valid & ~fill_start;
        load_c      = accept & host.req_we;
        if (fill_start) begin
          fill_go   = 1'b1;
          cnt_nxt   = 3'd0;
          state_nxt = FILL;
        end
      end
      FILL: begin
        load_c      = 1'b1;
        ram_address = cnt;
        ram_data_in = fill_val;
        cnt_nxt     = cnt + 3'd1;
        if (cnt == 3'd7) begin
          fill_last = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ram8 must never see a load while reset is held, even combinationally
  assign ram_load       = load_c & rst_n;
  assign host.req_ready = req_ready_c;
  assign host.rsp_valid = rsp_vld_p1;
  assign host.rsp_rdata = rsp_data_p1;

  // stage p0 -> p1: control state, fill latch and read response register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      busy        <= 1'b0;
      fill_done   <= 1'b0;
      fill_val    <= '0;
      rsp_vld_p1  <= 1'b0;
      rsp_data_p1 <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      busy       <= (state_nxt == FILL);
      fill_done  <= fill_last;
      rsp_vld_p1 <= accept & ~host.req_we;
      if (fill_go)
        fill_val <= fill_value;
      if (accept && !host.req_we)
        rsp_data_p1 <= ram_data_out;
    end
  end

endmodule

// File: tb/tb_ram8_port_ctrl.sv
// Directed bench for ram8_port_ctrl with a behavioural ram8 attached
// (combinational read, registered write).
module tb_ram8_port_ctrl;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fill_start;
  logic [DATA_W-1:0] fill_value;
  logic              busy, fill_done, ram_load;
  logic [2:0]        ram_address;
  logic [DATA_W-1:0] ram_data_in, ram_data_out;
  logic [DATA_W-1:0] mem [8];

  int nvec = 0;
  int nerr = 0;

  ram8_port_ctrl_if #(.DATA_W(DATA_W)) host ();

  ram8_port_ctrl #(.DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host         (host),
    .fill_start   (fill_start),
    .fill_value   (fill_value),
    .busy         (busy),
    .fill_done    (fill_done),
    .ram_load     (ram_load),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  always #5 clk = ~clk;

  initial for (int k = 0; k < 8; k++) mem[k] = '0;
  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_data_in;
  assign ram_data_out = mem[ram_address];

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic we, input logic [2:0] a, input logic [15:0] d);
    host.req_valid = v;
    host.req_we    = we;
    host.req_addr  = a;
    host.req_wdata = d;
  endtask

  // Runs the 8 fill cycles (already in FILL), optionally disturbing inputs.
  task automatic fill_cycles(input logic [15:0] val, input bit disturb);
    for (int i = 0; i < 8; i++) begin
      if (disturb) begin
        fill_start = (i != 7) && i[0];
        set_req(i != 7, 1'b1, 3'(7 - i), 16'hDEAD);
        fill_value = 16'hFFFF - 16'(i);
      end
      #1;
      check_vec("fill_load", ram_load, 1);
      check_vec("fill_addr", ram_address, i);
      check_vec("fill_data", ram_data_in, val);
      check_vec("fill_busy", busy, 1);
      check_vec("fill_ready", host.req_ready, 0);
      check_vec("fill_done_early", fill_done, 0);
      step();
    end
    check_vec("fill_done_pulse", fill_done, 1);
    check_vec("fill_done_busy", busy, 0);
  endtask

  // 8 back-to-back reads; expected base + (incr ? addr : 0).
  task automatic read_all(input logic [15:0] base, input bit incr);
    for (int a = 0; a < 8; a++) begin
      set_req(1'b1, 1'b0, 3'(a), 16'h0);
      #1;
      check_vec("rd_load", ram_load, 0);
      check_vec("rd_ready", host.req_ready, 1);
      step();
      check_vec("rd_valid", host.rsp_valid, 1);
      check_vec("rd_data", host.rsp_rdata, incr ? base + 16'(a) : base);
    end
    set_req(1'b0, 1'b0, 3'd0, 16'h0);
    step();
    check_vec("rd_valid_end", host.rsp_valid, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    fill_start = 1'b0;
    fill_value = 16'h0;
    set_req(1'b1, 1'b1, 3'd4, 16'hAAAA);
    #3;
    check_vec("rst_rsp_valid", host.rsp_valid, 0);
    check_vec("rst_rsp_rdata", host.rsp_rdata, 0);
    check_vec("rst_busy", busy, 0);
    check_vec("rst_fill_done", fill_done, 0);
    check_vec("rst_ram_load", ram_load, 0);
    step();
    step();
    rst_n = 1'b1;
    set_req(1'b0, 1'b0, 3'd0, 16'h0);
    #1;
    check_vec("rel_ready", host.req_ready, 1);
    check_vec("rel_mem4", mem[4], 0);

    // write 0x1234 @5, then read it back
    step();
    set_req(1'b1, 1'b1, 3'd5, 16'h1234);
    #1;
    check_vec("wr_load", ram_load, 1);
    check_vec("wr_addr", ram_address, 5);
    check_vec("wr_data", ram_data_in, 16'h1234);
    step();
    check_vec("wr_no_rsp", host.rsp_valid, 0);
    set_req(1'b1, 1'b0, 3'd5, 16'h0);
    step();
    check_vec("rd5_valid", host.rsp_valid, 1);
    check_vec("rd5_data", host.rsp_rdata, 16'h1234);
    set_req(1'b0, 1'b0, 3'd1, 16'h5555);
    #1;
    check_vec("idle_load", ram_load, 0);
    check_vec("idle_addr", ram_address, 1);
    check_vec("idle_data", ram_data_in, 16'h5555);
    step();
    check_vec("rd5_valid_off", host.rsp_valid, 0);
    check_vec("rd5_hold", host.rsp_rdata, 16'h1234);

    // plain fill with 0xBEEF
    fill_start = 1'b1;
    fill_value = 16'hBEEF;
    #1;
    check_vec("fs_ready", host.req_ready, 0);
    check_vec("fs_busy", busy, 0);
    step();
    fill_start = 1'b0;
    fill_cycles(16'hBEEF, 1'b0);
    step();
    check_vec("fill_done_off", fill_done, 0);
    read_all(16'hBEEF, 1'b0);

    // back-to-back writes, read-after-write, then sequential reads
    for (int a = 0; a < 8; a++) begin
      set_req(1'b1, 1'b1, 3'(a), 16'hC0D0 + 16'(a));
      step();
    end
    set_req(1'b1, 1'b1, 3'd3, 16'h0BAD);
    step();
    set_req(1'b1, 1'b0, 3'd3, 16'h0);
    step();
    check_vec("raw_data", host.rsp_rdata, 16'h0BAD);
    set_req(1'b1, 1'b1, 3'd3, 16'hC0D3);
    step();
    read_all(16'hC0D0, 1'b1);

    // fill colliding with a write request
    fill_start = 1'b1;
    fill_value = 16'h1111;
    set_req(1'b1, 1'b1, 3'd2, 16'h0001);
    #1;
    check_vec("col_ready", host.req_ready, 0);
    check_vec("col_load", ram_load, 0);
    step();
    fill_start = 1'b0;
    fill_cycles(16'h1111, 1'b0);
    #1;
    check_vec("col_acc_load", ram_load, 1);
    check_vec("col_acc_addr", ram_address, 2);
    check_vec("col_acc_data", ram_data_in, 16'h0001);
    step();
    set_req(1'b1, 1'b0, 3'd2, 16'h0);
    step();
    check_vec("col_rd2", host.rsp_rdata, 16'h0001);
    set_req(1'b1, 1'b0, 3'd1, 16'h0);
    step();
    check_vec("col_rd1", host.rsp_rdata, 16'h1111);
    set_req(1'b0, 1'b0, 3'd0, 16'h0);
    step();

    // inputs disturbed during fill
    fill_start = 1'b1;
    fill_value = 16'h5A5A;
    step();
    fill_cycles(16'h5A5A, 1'b1);
    step();
    check_vec("dist_done_off", fill_done, 0);
    read_all(16'h5A5A, 1'b0);

    // back-to-back fills with fill_start held
    fill_start = 1'b1;
    fill_value = 16'h2222;
    step();
    fill_value = 16'h3333;
    fill_cycles(16'h2222, 1'b0);
    #1;
    check_vec("b2b_ready", host.req_ready, 0);
    check_vec("b2b_load", ram_load, 0);
    step();
    fill_start = 1'b0;
    check_vec("b2b_busy", busy, 1);
    check_vec("b2b_done_off", fill_done, 0);
    fill_cycles(16'h3333, 1'b0);
    step();

    // reset in the middle of a fill
    fill_start = 1'b1;
    fill_value = 16'h7777;
    step();
    fill_start = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_vec("abort_busy", busy, 0);
    check_vec("abort_load", ram_load, 0);
    check_vec("abort_done", fill_done, 0);
    step();
    rst_n = 1'b1;
    #1;
    check_vec("abort_ready", host.req_ready, 1);
    step();
    check_vec("abort_no_done", fill_done, 0);
    check_vec("abort_busy2", busy, 0);
    set_req(1'b1, 1'b0, 3'd2, 16'h0);
    step();
    check_vec("abort_rd2", host.rsp_rdata, 16'h7777);
    set_req(1'b1, 1'b0, 3'd3, 16'h0);
    step();
    check_vec("abort_rd3", host.rsp_rdata, 16'h3333);
    set_req(1'b0, 1'b0, 3'd0, 16'h0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
